// File: rtl/cla_subtractor_seq.sv
// Sequential subtractor: diff = a - b - bin, one 4-bit lookahead slice per clock,
// LSB nibble first, with the borrow carried between slices as an inverted carry.
module cla_subtractor_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int NIB = WIDTH / 32'sd4;
   localparam int IW  = (NIB > 32'sd1) ? $clog2(NIB) : 32'sd1;

   generate
      if ((WIDTH % 32'sd4 != 32'sd0) || (WIDTH < 32'sd4)) begin : g_bad_width
         $error("cla_subtractor_seq: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic [3:0]       x_s, y_s, p_s, g_s;
   logic [4:0]       c_s;
   int               base_s;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   // Next-state and slice datapath: subtraction as a + ~b + carry, carry starts at ~bin
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      base_s  = int'(idx_q) * 32'sd4;
      x_s     = a_q[base_s +: 4];
      y_s     = ~b_q[base_s +: 4];
      p_s     = x_s ^ y_s;
      g_s     = x_s & y_s;
      c_s[0]  = carry_q;
      c_s[1]  = g_s[0] | (p_s[0] & c_s[0]);
      c_s[2]  = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_s[0]);
      c_s[3]  = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
              | (p_s[2] & p_s[1] & p_s[0] & c_s[0]);
      c_s[4]  = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
              | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
              | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_s[0]);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = ~bin;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            diff_d[base_s +: 4] = p_s ^ c_s[3:0];
            carry_d             = c_s[4];
            if (idx_q == IW'(NIB - 32'sd1)) begin
               state_d = DONE;
               bout_d  = ~c_s[4];
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);
               zero_d  = ~|diff_d;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_cla_subtractor_seq.sv
// Scoreboard bench for cla_subtractor_seq (WIDTH=16): directed vectors with
// hand-computed results, backpressure, mid-run reset, then random traffic.
module tb_cla_subtractor_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0000;
   logic [15:0] b = 16'h0000;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] diff;
   logic        bout, ovf, zero;

   int          checks = 0;
   int          errors = 0;
   int          ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
   logic [18:0] exp_q[$];

   cla_subtractor_seq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] pack(input logic bo, input logic ov, input logic z,
                                        input logic [15:0] d);
      return {bo, ov, z, d};
   endfunction

   function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mbin);
      logic [16:0] r;
      logic        o;
      r = {1'b0, ma} - {1'b0, mb} - {16'h0000, mbin};
      o = (ma[15] ^ mb[15]) & (r[15] ^ ma[15]);
      return {r[16], o, (r[15:0] == 16'h0000), r[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                       input logic push, input logic [18:0] e);
      int n;
      @(negedge clk);
      a = va; b = vb; bin = vbin; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      if (push) exp_q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rbin;
      int          n;

      fork
         // Output readiness driver
         forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
               0:       out_ready = 1'b1;
               1:       out_ready = ($urandom_range(0, 2) != 0);
               default: out_ready = 1'b0;
            endcase
         end
         // Monitor: pop and compare on every accepted result
         forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_output", {13'd0, bout, ovf, zero, diff}, 32'd0);
               end else begin
                  check("result", {13'd0, bout, ovf, zero, diff}, {13'd0, exp_q.pop_front()});
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_outputs", {13'd0, bout, ovf, zero, diff}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Test 1 with latency: out_valid rises exactly 4 edges after accept
      send(16'h1234, 16'h0234, 1'b0, 1'b1, pack(1'b0, 1'b0, 1'b0, 16'h1000));
      repeat (3) @(posedge clk);
      #1 check("latency_3", {31'd0, out_valid}, 32'd0);
      @(posedge clk);
      #1 check("latency_4", {31'd0, out_valid}, 32'd1);
      drain();

      // Tests 2-4
      send(16'h0000, 16'h0001, 1'b0, 1'b1, pack(1'b1, 1'b0, 1'b0, 16'hFFFF));
      send(16'h8000, 16'h0001, 1'b0, 1'b1, pack(1'b0, 1'b1, 1'b0, 16'h7FFF));
      send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, pack(1'b1, 1'b1, 1'b0, 16'h8000));
      send(16'h0005, 16'h0004, 1'b1, 1'b1, pack(1'b0, 1'b0, 1'b1, 16'h0000));
      send(16'h0000, 16'h0000, 1'b1, 1'b1, pack(1'b1, 1'b0, 1'b0, 16'hFFFF));
      drain();

      // Test 5: backpressure, busy in_valid ignored
      ready_mode = 2;
      @(posedge clk);
      send(16'h1234, 16'h1111, 1'b0, 1'b1, pack(1'b0, 1'b0, 1'b0, 16'h0123));
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) begin
            a = 16'hAAAA; b = 16'h0000; bin = 1'b0; in_valid = 1'b1;
         end
         check("stall_hold", {11'd0, out_valid, in_ready, bout, ovf, zero, diff},
               {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0123});
      end
      in_valid = 1'b0;
      ready_mode = 0;
      send(16'h0100, 16'h0001, 1'b0, 1'b1, pack(1'b0, 1'b0, 1'b0, 16'h00FF));
      drain();

      // Test 6: reset sampled at the slice-2 edge aborts the operation
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 19'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_in_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("abort_no_valid", {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      send(16'hFFFF, 16'h0001, 1'b1, 1'b1, pack(1'b0, 1'b0, 1'b0, 16'hFFFD));
      drain();

      // Random traffic with random consumer stalls
      ready_mode = 1;
      for (int i = 0; i < 30; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbin = 1'($urandom_range(0, 1));
         send(ra, rb, rbin, 1'b1, model(ra, rb, rbin));
      end
      drain();
      ready_mode = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
